branch_requester: RTL and testbench

//  Front-end client of the 2-bit saturating branch predictor. Accepts branches from fetch, issues

---
 rtl/branch_pkg.sv | 11 +
 rtl/pred_queue.sv | 49 ++++
 rtl/branch_requester.sv | 100 ++++++++++
 tb/tb_branch_requester.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared state encoding for the branch requester FSM and the predictor bench.
package branch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t REQ  = 2'd1;
    localparam state_t WAIT = 2'd2;
    localparam state_t UPD  = 2'd3;

endpackage

// File: rtl/pred_queue.sv
// In-order FIFO of 1-bit predictions awaiting their resolved outcome.
module pred_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         din,
    input  logic                         pop,
    output logic                         dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_B = $clog2(DEPTH+1);

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_B'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; a flush only clears the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_B'(1);
            else if (do_pop && !do_push) count <= count - CNT_B'(1);
        end
    end

endmodule

// File: rtl/branch_requester.sv
// Sequences predictor requests and outcome updates for fetch/execute, one transaction at a time.
module branch_requester
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         br_valid,
    output logic                         br_ready,
    output logic                         pred_valid,
    output logic                         pred_taken,
    input  logic                         res_valid,
    input  logic                         res_taken,
    output logic                         res_ready,
    output logic                         mispredict,
    output logic                         request,
    output logic                         result,
    output logic                         taken,
    input  logic                         prediction,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic [CNT_W-1:0]             branch_cnt,
    output logic [CNT_W-1:0]             mispredict_cnt
);

    state_t state;
    state_t state_nxt;
    logic   taken_q;
    logic   miss_q;
    logic   q_head;
    logic   q_full;
    logic   q_empty;
    logic   res_acc;
    logic   br_acc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (state == WAIT),
        .din   (prediction),
        .pop   (res_acc),
        .dout  (q_head),
        .count (outstanding),
        .full  (q_full),
        .empty (q_empty)
    );

    // Resolution wins over a new branch so a full queue can always drain.
    assign res_ready = (state == IDLE) & ~q_empty;
    assign res_acc   = res_valid & res_ready;
    assign br_ready  = (state == IDLE) & ~q_full & ~(res_valid & ~q_empty);
    assign br_acc    = br_valid & br_ready;

    assign request    = (state == REQ);
    assign pred_valid = (state == WAIT);
    assign pred_taken = (state == WAIT) & prediction;
    assign result     = (state == UPD);
    assign taken      = (state == UPD) & taken_q;
    assign mispredict = (state == UPD) & miss_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (res_acc) state_nxt = UPD;
                     else if (br_acc) state_nxt = REQ;
            REQ:     state_nxt = WAIT;
            WAIT:    state_nxt = IDLE;
            UPD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == UPD) begin
                branch_cnt <= sat_inc(branch_cnt);
                if (miss_q) mispredict_cnt <= sat_inc(mispredict_cnt);
            end
        end
    end

    // Outcome latches are only observed through UPD-qualified outputs.
    always_ff @(posedge clk) begin
        if (res_acc) begin
            taken_q <= res_taken;
            miss_q  <= (q_head != res_taken);
        end
    end

endmodule

// File: tb/tb_branch_requester.sv
// Directed bench for branch_requester with a 2-bit saturating predictor model.
module tb_branch_requester;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic        br_ready, pred_valid, pred_taken, res_ready, mispredict;
    logic        request, result, taken;
    logic [2:0]  outstanding;
    logic [15:0] branch_cnt, mispredict_cnt;

    logic [1:0]  pcnt = 2'b11;
    logic        ppred = 1'b0;

    logic        br_valid2 = 1'b0;
    logic        res_valid2 = 1'b0;
    logic        pred2 = 1'b1;
    logic        br_ready2, pred_valid2, pred_taken2, res_ready2, mispredict2;
    logic        request2, result2, taken2;
    logic [2:0]  outstanding2;
    logic [1:0]  branch_cnt2, mispredict_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_requester #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_ready(br_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
        .mispredict(mispredict), .request(request), .result(result), .taken(taken),
        .prediction(ppred), .outstanding(outstanding),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_requester #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid2), .br_ready(br_ready2),
        .pred_valid(pred_valid2), .pred_taken(pred_taken2),
        .res_valid(res_valid2), .res_taken(1'b0), .res_ready(res_ready2),
        .mispredict(mispredict2), .request(request2), .result(result2), .taken(taken2),
        .prediction(pred2), .outstanding(outstanding2),
        .branch_cnt(branch_cnt2), .mispredict_cnt(mispredict_cnt2)
    );

    // Predictor model: not reset, answers the cycle after request, ignores updates under request.
    always @(posedge clk) begin
        if (request) ppred <= pcnt[1];
        else if (result) begin
            if (taken && pcnt != 2'b11) pcnt <= pcnt + 2'b01;
            else if (!taken && pcnt != 2'b00) pcnt <= pcnt - 2'b01;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("no_req_and_res", {31'd0, request & result}, 32'd0);
        check("no_req_and_res2", {31'd0, request2 & result2}, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_branch(input logic exp_pred);
        br_valid = 1'b1;
        #1 check("br_ready", br_ready, 1);
        tick();
        br_valid = 1'b0;
        #1 check("request", request, 1);
        check("pred_valid_early", pred_valid, 0);
        tick();
        check("pred_valid", pred_valid, 1);
        check("pred_taken", pred_taken, exp_pred);
        check("request_once", request, 0);
        tick();
    endtask

    task automatic send_res(input logic t, input logic exp_miss);
        res_valid = 1'b1;
        res_taken = t;
        #1 check("res_ready", res_ready, 1);
        tick();
        res_valid = 1'b0;
        #1 check("result", result, 1);
        check("taken", taken, t);
        check("mispredict", mispredict, exp_miss);
        check("request_in_upd", request, 0);
        tick();
    endtask

    initial begin
        // 1: reset, then reset again mid-WAIT
        tick(); tick();
        rst_n = 1'b1;
        br_valid = 1'b1;
        #1 check("t1_br_ready", br_ready, 1);
        tick();
        br_valid = 1'b0;
        check("t1_request", request, 1);
        tick();
        check("t1_in_wait", pred_valid, 1);
        rst_n = 1'b0;
        #1 check("t1_rst_pred_valid", pred_valid, 0);
        check("t1_rst_pred_taken", pred_taken, 0);
        check("t1_rst_request", request, 0);
        check("t1_rst_result", result, 0);
        check("t1_rst_outstanding", outstanding, 0);
        check("t1_rst_mispredict", mispredict, 0);
        tick();
        rst_n = 1'b1;
        #1 check("t1_post_br_ready", br_ready, 1);
        check("t1_post_res_ready", res_ready, 0);
        check("t1_post_branch_cnt", branch_cnt, 0);

        // 2: fresh predictor predicts taken, outcome not taken
        send_branch(1'b1);
        check("t2_outstanding", outstanding, 1);
        send_res(1'b0, 1'b1);
        check("t2_branch_cnt", branch_cnt, 1);
        check("t2_mispredict_cnt", mispredict_cnt, 1);

        // 3: fill to DEPTH, fifth branch held until a resolution is taken
        for (int i = 0; i < 4; i++) send_branch(1'b1);
        check("t3_outstanding_full", outstanding, 4);
        check("t3_br_ready_full", br_ready, 0);
        br_valid = 1'b1;
        tick();
        check("t3_held_request", request, 0);
        check("t3_held_br_ready", br_ready, 0);
        res_valid = 1'b1;
        res_taken = 1'b1;
        #1 check("t3_res_ready", res_ready, 1);
        tick();
        res_valid = 1'b0;
        check("t3_result", result, 1);
        check("t3_mispredict", mispredict, 0);
        tick();
        check("t3_outstanding_3", outstanding, 3);
        check("t3_br_ready_freed", br_ready, 1);
        tick();
        br_valid = 1'b0;
        check("t3_request", request, 1);
        tick();
        check("t3_pred_taken", pred_taken, 1);
        tick();
        check("t3_outstanding_4", outstanding, 4);
        check("t3_branch_cnt", branch_cnt, 2);

        // 4: both offered with two outstanding, update goes first
        send_res(1'b1, 1'b0);
        send_res(1'b1, 1'b0);
        check("t4_outstanding", outstanding, 2);
        br_valid = 1'b1;
        res_valid = 1'b1;
        res_taken = 1'b0;
        #1 check("t4_res_ready", res_ready, 1);
        check("t4_br_ready", br_ready, 0);
        tick();
        res_valid = 1'b0;
        check("t4_result_first", result, 1);
        check("t4_mispredict", mispredict, 1);
        tick();
        check("t4_br_ready_after", br_ready, 1);
        tick();
        br_valid = 1'b0;
        check("t4_request_second", request, 1);
        tick();
        check("t4_pred_taken", pred_taken, 1);
        tick();
        check("t4_outstanding_end", outstanding, 2);
        check("t4_branch_cnt", branch_cnt, 5);
        check("t4_mispredict_cnt", mispredict_cnt, 2);

        // 5: outcome offered with an empty queue is ignored
        send_res(1'b1, 1'b0);
        send_res(1'b1, 1'b0);
        check("t5_empty", outstanding, 0);
        res_valid = 1'b1;
        res_taken = 1'b0;
        #1 check("t5_res_ready", res_ready, 0);
        tick();
        check("t5_result", result, 0);
        tick();
        res_valid = 1'b0;
        check("t5_result_late", result, 0);
        check("t5_branch_cnt", branch_cnt, 7);
        check("t5_mispredict_cnt", mispredict_cnt, 2);

        // 6: 2-bit counters saturate at 3 over five mispredicts
        for (int i = 0; i < 5; i++) begin
            br_valid2 = 1'b1;
            tick();
            br_valid2 = 1'b0;
            tick();
            tick();
            res_valid2 = 1'b1;
            tick();
            res_valid2 = 1'b0;
            check("t6_mispredict", mispredict2, 1);
            tick();
            check("t6_mispredict_cnt", mispredict_cnt2, (i < 3) ? i + 1 : 3);
            check("t6_branch_cnt", branch_cnt2, (i < 3) ? i + 1 : 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
